// File: rtl/exibidor_hex_16.sv
// Time-multiplexed driver for a 4-digit seven-segment display. A loaded halfword
// is held in a buffer and only becomes the displayed value at a frame boundary.
module exibidor_hex_16 #(
    parameter int DIV_CICLOS  = 50000,
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] entrada_16,
    input  logic        carrega,
    input  logic        apaga_zeros,
    output logic [6:0]  segmentos,
    output logic [3:0]  anodos,
    output logic        pronto
);
    localparam int               DIV_W   = (DIV_CICLOS > 1) ? $clog2(DIV_CICLOS) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_CICLOS - 1);
    localparam logic [6:0]       SEG_OFF = ATIVO_BAIXO ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF  = ATIVO_BAIXO ? 4'hF : 4'h0;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [15:0]      r_buffer;
    logic             r_pendente;
    logic [15:0]      r_valor;
    logic             r_pronto;
    logic [6:0]       r_segmentos;
    logic [3:0]       r_anodos;

    logic             w_tick;
    logic             w_commit;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [6:0]       w_dec;
    logic [6:0]       w_seg_ah;
    logic [3:0]       w_an_ah;

    assign w_tick   = (r_div == DIV_MAX);
    assign w_commit = w_tick && (r_idx == 2'd3) && r_pendente;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // The commit reads the buffer as it was before this edge; a simultaneous
    // load lands in the buffer and stays pending for the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buffer   <= 16'h0000;
            r_pendente <= 1'b0;
            r_valor    <= 16'h0000;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= w_commit;
            if (w_commit) begin
                r_valor <= r_buffer;
            end
            if (carrega) begin
                r_buffer   <= entrada_16;
                r_pendente <= 1'b1;
            end else if (w_commit) begin
                r_pendente <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        case (r_idx)
            2'd0: w_nibble = r_valor[3:0];
            2'd1: begin
                w_nibble = r_valor[7:4];
                w_blank  = apaga_zeros && (r_valor[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble = r_valor[11:8];
                w_blank  = apaga_zeros && (r_valor[15:8] == 8'h00);
            end
            default: begin
                w_nibble = r_valor[15:12];
                w_blank  = apaga_zeros && (r_valor[15:12] == 4'h0);
            end
        endcase
    end

    // Active-high gfedcba patterns.
    always_comb begin
        w_dec = 7'h00;
        case (w_nibble)
            4'h0: w_dec = 7'h3F;
            4'h1: w_dec = 7'h06;
            4'h2: w_dec = 7'h5B;
            4'h3: w_dec = 7'h4F;
            4'h4: w_dec = 7'h66;
            4'h5: w_dec = 7'h6D;
            4'h6: w_dec = 7'h7D;
            4'h7: w_dec = 7'h07;
            4'h8: w_dec = 7'h7F;
            4'h9: w_dec = 7'h6F;
            4'hA: w_dec = 7'h77;
            4'hB: w_dec = 7'h7C;
            4'hC: w_dec = 7'h39;
            4'hD: w_dec = 7'h5E;
            4'hE: w_dec = 7'h79;
            default: w_dec = 7'h71;
        endcase
    end

    assign w_seg_ah = w_blank ? 7'h00 : w_dec;
    assign w_an_ah  = w_blank ? 4'h0 : (4'b0001 << r_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_segmentos <= SEG_OFF;
            r_anodos    <= AN_OFF;
        end else begin
            r_segmentos <= ATIVO_BAIXO ? ~w_seg_ah : w_seg_ah;
            r_anodos    <= ATIVO_BAIXO ? ~w_an_ah : w_an_ah;
        end
    end

    assign segmentos = r_segmentos;
    assign anodos    = r_anodos;
    assign pronto    = r_pronto;

endmodule
